// File: rtl/instr_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | instr_encoder: two-stage RV32I instruction word assembler/emitter |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module instr_encoder #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'd0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  restart_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [3:0]            fmt_i,
  input  logic [4:0]            rd_i,
  input  logic [4:0]            rs1_i,
  input  logic [4:0]            rs2_i,
  input  logic [2:0]            funct3_i,
  input  logic [6:0]            funct7_i,
  input  logic [31:0]           imm_i,
  output logic                  wr_valid_o,
  input  logic                  wr_ready_i,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [31:0]           wr_data_o,
  output logic                  err_o,
  output logic [ADDR_WIDTH:0]   count_o
);

  localparam logic [ADDR_WIDTH-1:0] c_BASE = BASE_ADDR[ADDR_WIDTH-1:0];

  localparam logic [3:0] c_FMT_LOAD   = 4'd0;
  localparam logic [3:0] c_FMT_STORE  = 4'd1;
  localparam logic [3:0] c_FMT_RTYPE  = 4'd2;
  localparam logic [3:0] c_FMT_ITYPE  = 4'd3;
  localparam logic [3:0] c_FMT_JAL    = 4'd4;
  localparam logic [3:0] c_FMT_JALR   = 4'd5;
  localparam logic [3:0] c_FMT_BRANCH = 4'd6;
  localparam logic [3:0] c_FMT_LUI    = 4'd7;
  localparam logic [3:0] c_FMT_AUIPC  = 4'd8;
  localparam logic [3:0] c_FMT_SYSTEM = 4'd9;

  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

  logic                  r_s1_valid, r_s1_legal;
  logic [3:0]            r_s1_fmt;
  logic [4:0]            r_s1_rd, r_s1_rs1, r_s1_rs2;
  logic [2:0]            r_s1_f3;
  logic [6:0]            r_s1_f7;
  logic [31:0]           r_s1_imm;
  logic                  r_s2_valid;
  logic [31:0]           r_s2_data;
  logic [ADDR_WIDTH-1:0] r_s2_addr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_err;

  logic                  w_req_legal;
  logic                  w_s1_adv;
  logic                  w_accept;
  logic                  w_s2_load;
  logic [31:0]           w_word;

  // Control-flow targets must be halfword aligned; anything past system is undefined.
  assign w_req_legal = (fmt_i <= c_FMT_SYSTEM) &&
                       !(((fmt_i == c_FMT_BRANCH) || (fmt_i == c_FMT_JAL)) && imm_i[0]);
  assign w_s1_adv    = !r_s2_valid || wr_ready_i;
  assign req_ready_o = !restart_i && (!r_s1_valid || w_s1_adv);
  assign w_accept    = req_valid_i && req_ready_o;
  assign w_s2_load   = r_s1_valid && r_s1_legal && w_s1_adv;

  always_comb begin
    w_word = '0;
    case (r_s1_fmt)
      c_FMT_LOAD:   w_word = {r_s1_imm[11:0], r_s1_rs1, r_s1_f3, r_s1_rd, c_OP_LOAD};
      c_FMT_STORE:  w_word = {r_s1_imm[11:5], r_s1_rs2, r_s1_rs1, r_s1_f3, r_s1_imm[4:0], c_OP_STORE};
      c_FMT_RTYPE:  w_word = {r_s1_f7, r_s1_rs2, r_s1_rs1, r_s1_f3, r_s1_rd, c_OP_RTYPE};
      c_FMT_ITYPE: begin
        if ((r_s1_f3 == 3'b001) || (r_s1_f3 == 3'b101))
          w_word = {r_s1_f7, r_s1_imm[4:0], r_s1_rs1, r_s1_f3, r_s1_rd, c_OP_ITYPE};
        else
          w_word = {r_s1_imm[11:0], r_s1_rs1, r_s1_f3, r_s1_rd, c_OP_ITYPE};
      end
      c_FMT_JAL:    w_word = {r_s1_imm[20], r_s1_imm[10:1], r_s1_imm[11], r_s1_imm[19:12],
                              r_s1_rd, c_OP_JAL};
      c_FMT_JALR:   w_word = {r_s1_imm[11:0], r_s1_rs1, r_s1_f3, r_s1_rd, c_OP_JALR};
      c_FMT_BRANCH: w_word = {r_s1_imm[12], r_s1_imm[10:5], r_s1_rs2, r_s1_rs1, r_s1_f3,
                              r_s1_imm[4:1], r_s1_imm[11], c_OP_BRANCH};
      c_FMT_LUI:    w_word = {r_s1_imm[31:12], r_s1_rd, c_OP_LUI};
      c_FMT_AUIPC:  w_word = {r_s1_imm[31:12], r_s1_rd, c_OP_AUIPC};
      c_FMT_SYSTEM: w_word = {r_s1_imm[11:0], r_s1_rs1, r_s1_f3, r_s1_rd, c_OP_SYSTEM};
      default:      w_word = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_legal <= 1'b0;
      r_s1_fmt   <= '0;
      r_s1_rd    <= '0;
      r_s1_rs1   <= '0;
      r_s1_rs2   <= '0;
      r_s1_f3    <= '0;
      r_s1_f7    <= '0;
      r_s1_imm   <= '0;
    end else if (restart_i) begin
      r_s1_valid <= 1'b0;
    end else if (req_ready_o) begin
      r_s1_valid <= req_valid_i;
      if (w_accept) begin
        r_s1_legal <= w_req_legal;
        r_s1_fmt   <= fmt_i;
        r_s1_rd    <= rd_i;
        r_s1_rs1   <= rs1_i;
        r_s1_rs2   <= rs2_i;
        r_s1_f3    <= funct3_i;
        r_s1_f7    <= funct7_i;
        r_s1_imm   <= imm_i;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_addr  <= c_BASE;
      r_addr     <= c_BASE;
      r_count    <= '0;
      r_err      <= 1'b0;
    end else if (restart_i) begin
      r_s2_valid <= 1'b0;
      r_addr     <= c_BASE;
      r_count    <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_s2_load) begin
        r_s2_valid <= 1'b1;
        r_s2_data  <= w_word;
        r_s2_addr  <= r_addr;
        r_addr     <= r_addr + ADDR_WIDTH'(1);
      end else if (wr_ready_i) begin
        r_s2_valid <= 1'b0;
      end
      if (r_s2_valid && wr_ready_i)
        r_count <= r_count + (ADDR_WIDTH+1)'(1);
      if (r_s1_valid && !r_s1_legal && w_s1_adv)
        r_err <= 1'b1;
    end
  end

  assign wr_valid_o = r_s2_valid;
  assign wr_data_o  = r_s2_data;
  assign wr_addr_o  = r_s2_addr;
  assign err_o      = r_err;
  assign count_o    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// tb_instr_encoder: vector table + scoreboard bench for instr_encoder.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        restart_i = 1'b0;
  logic        req_valid_i = 1'b0;
  wire         req_ready_o;
  logic [3:0]  fmt_i = '0;
  logic [4:0]  rd_i = '0, rs1_i = '0, rs2_i = '0;
  logic [2:0]  funct3_i = '0;
  logic [6:0]  funct7_i = '0;
  logic [31:0] imm_i = '0;
  wire         wr_valid_o;
  logic        wr_ready_i;
  wire  [9:0]  wr_addr_o;
  wire  [31:0] wr_data_o;
  wire         err_o;
  wire  [10:0] count_o;

  logic        rv2 = 1'b0;
  logic        wr_ready2 = 1'b1;
  wire         rr2, wv2, err2;
  wire  [1:0]  wa2;
  wire  [31:0] wd2;
  wire  [2:0]  cnt2;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_WIDTH(10), .BASE_ADDR(32'd0)) dut (
    .clk(clk), .reset(reset), .restart_i(restart_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .fmt_i(fmt_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .funct3_i(funct3_i), .funct7_i(funct7_i), .imm_i(imm_i),
    .wr_valid_o(wr_valid_o), .wr_ready_i(wr_ready_i),
    .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .err_o(err_o), .count_o(count_o)
  );

  instr_encoder #(.ADDR_WIDTH(2), .BASE_ADDR(32'd0)) dut_wrap (
    .clk(clk), .reset(reset), .restart_i(1'b0),
    .req_valid_i(rv2), .req_ready_o(rr2),
    .fmt_i(4'd3), .rd_i(5'd1), .rs1_i(5'd0), .rs2_i(5'd0),
    .funct3_i(3'd0), .funct7_i(7'd0), .imm_i(32'd1),
    .wr_valid_o(wv2), .wr_ready_i(wr_ready2),
    .wr_addr_o(wa2), .wr_data_o(wd2),
    .err_o(err2), .count_o(cnt2)
  );

  typedef struct {
    logic [3:0]  fmt;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        legal;
    logic [31:0] word;
  } vec_t;

  typedef struct {
    logic [31:0] word;
    logic [9:0]  addr;
    int          cyc;
    bit          lat;
  } exp_t;

  vec_t       vecs [0:13];
  exp_t       sb [$];
  logic [1:0] q2 [$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc = 0;
  logic [9:0] exp_addr = '0;
  bit         rdy_rand = 1'b0;
  logic       rdy_val  = 1'b1;

  function automatic vec_t mk(input logic [3:0] fmt, input logic [4:0] rd, rs1, rs2,
                              input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] imm, input logic legal,
                              input logic [31:0] word);
    vec_t v;
    v.fmt = fmt; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.f3 = f3; v.f7 = f7;
    v.imm = imm; v.legal = legal; v.word = word;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    wr_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      wr_ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
    end
  end

  // Scoreboard: pop on every handshake and verify the word stays put while stalled.
  bit          hv = 1'b0;
  logic [31:0] hd;
  logic [9:0]  ha;
  always @(negedge clk) begin
    exp_t e;
    if (reset || restart_i) begin
      hv = 1'b0;
    end else begin
      if (hv) begin
        check("hold_valid", 32'(wr_valid_o), 32'd1);
        check("hold_data", wr_data_o, hd);
        check("hold_addr", 32'(wr_addr_o), 32'(ha));
      end
      if (wr_valid_o && wr_ready_i) begin
        if (sb.size() == 0) begin
          check("unexpected_word", wr_data_o, 32'hxxxx_xxxx);
        end else begin
          e = sb.pop_front();
          check("word", wr_data_o, e.word);
          check("addr", 32'(wr_addr_o), 32'(e.addr));
          if (e.lat) check("latency", 32'(cyc - e.cyc), 32'd2);
        end
      end
      hv = wr_valid_o && !wr_ready_i;
      hd = wr_data_o;
      ha = wr_addr_o;
    end
  end

  always @(negedge clk) if (!reset && wv2 && wr_ready2) q2.push_back(wa2);

  task automatic drive(input int idx);
    fmt_i = vecs[idx].fmt; rd_i = vecs[idx].rd; rs1_i = vecs[idx].rs1;
    rs2_i = vecs[idx].rs2; funct3_i = vecs[idx].f3; funct7_i = vecs[idx].f7;
    imm_i = vecs[idx].imm;
  endtask

  // Called and returns 1 time unit after a rising edge.
  task automatic send(input int idx, input bit lat);
    exp_t e;
    bit   ok = 1'b0;
    drive(idx);
    req_valid_i = 1'b1;
    for (int b = 0; b < 200 && !ok; b++) begin
      @(negedge clk);
      if (req_ready_o) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!ok) fail_now("send_accept");
    else if (vecs[idx].legal) begin
      e.word = vecs[idx].word; e.addr = exp_addr; e.cyc = cyc; e.lat = lat;
      sb.push_back(e);
      exp_addr = exp_addr + 10'd1;
    end
    @(posedge clk); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic drain();
    for (int b = 0; b < 1000 && sb.size() != 0; b++) @(negedge clk);
    if (sb.size() != 0) begin
      fail_now("drain");
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic do_restart();
    restart_i = 1'b1;
    @(negedge clk);
    sb.delete();
    exp_addr = '0;
    @(posedge clk); #1;
    restart_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_valid"}, 32'(wr_valid_o), 32'd0);
    check({tag, "_wr_data"}, wr_data_o, 32'd0);
    check({tag, "_wr_addr"}, 32'(wr_addr_o), 32'd0);
    check({tag, "_err"}, 32'(err_o), 32'd0);
    check({tag, "_count"}, 32'(count_o), 32'd0);
    check({tag, "_req_ready"}, 32'(req_ready_o), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc;
    vecs[0]  = mk(4'd3,  5'd1,  5'd0,  5'd0,  3'd0, 7'h7F, 32'h0000_0005, 1'b1, 32'h0050_0093);
    vecs[1]  = mk(4'd2,  5'd3,  5'd1,  5'd2,  3'd0, 7'h00, 32'h0000_0000, 1'b1, 32'h0020_81B3);
    vecs[2]  = mk(4'd1,  5'd9,  5'd1,  5'd2,  3'd2, 7'h00, 32'h0000_0008, 1'b1, 32'h0020_A423);
    vecs[3]  = mk(4'd6,  5'd0,  5'd1,  5'd2,  3'd0, 7'h00, 32'hFFFF_FFFC, 1'b1, 32'hFE20_8EE3);
    vecs[4]  = mk(4'd4,  5'd1,  5'd5,  5'd0,  3'd3, 7'h00, 32'h0000_0008, 1'b1, 32'h0080_00EF);
    vecs[5]  = mk(4'd7,  5'd5,  5'd31, 5'd31, 3'd7, 7'h7F, 32'h1234_5ABC, 1'b1, 32'h1234_52B7);
    vecs[6]  = mk(4'd0,  5'd2,  5'd3,  5'd0,  3'd2, 7'h00, 32'hFFFF_FFFF, 1'b1, 32'hFFF1_A103);
    vecs[7]  = mk(4'd3,  5'd1,  5'd1,  5'd0,  3'd5, 7'h20, 32'h0000_0023, 1'b1, 32'h4030_D093);
    vecs[8]  = mk(4'd8,  5'd10, 5'd0,  5'd0,  3'd0, 7'h00, 32'hABCD_E123, 1'b1, 32'hABCD_E517);
    vecs[9]  = mk(4'd5,  5'd0,  5'd1,  5'd0,  3'd0, 7'h00, 32'h0000_0000, 1'b1, 32'h0000_8067);
    vecs[10] = mk(4'd9,  5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'h0000_0001, 1'b1, 32'h0010_0073);
    vecs[11] = mk(4'd4,  5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'hFFFF_FFF8, 1'b1, 32'hFF9F_F06F);
    vecs[12] = mk(4'd12, 5'd1,  5'd1,  5'd1,  3'd0, 7'h00, 32'h0000_0000, 1'b0, 32'h0000_0000);
    vecs[13] = mk(4'd6,  5'd0,  5'd1,  5'd2,  3'd0, 7'h00, 32'h0000_0003, 1'b0, 32'h0000_0000);

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;

    // One request at a time; checks encoding, address order and latency.
    for (int i = 0; i < 12; i++) begin
      send(i, 1'b1);
      drain();
    end
    check("singles_count", 32'(count_o), 32'd12);
    check("singles_err", 32'(err_o), 32'd0);

    do_restart();
    check("restart1_count", 32'(count_o), 32'd0);
    send(12, 1'b0);
    send(13, 1'b0);
    send(0, 1'b1);
    drain();
    check("illegal_err", 32'(err_o), 32'd1);
    check("illegal_count", 32'(count_o), 32'd1);

    do_restart();
    check("restart2_err", 32'(err_o), 32'd0);
    rdy_rand = 1'b1;
    for (int i = 0; i < 6; i++) send(i, 1'b0);
    drain();
    rdy_rand = 1'b0;
    rdy_val  = 1'b1;
    @(posedge clk); #1;
    check("bp_count", 32'(count_o), 32'd6);

    rdy_val = 1'b0;
    send(12, 1'b0);
    send(0, 1'b0);
    send(1, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    drive(2);
    req_valid_i = 1'b1;
    @(negedge clk);
    check("stall_req_ready", 32'(req_ready_o), 32'd0);
    check("stall_wr_valid", 32'(wr_valid_o), 32'd1);
    check("stall_err", 32'(err_o), 32'd1);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    rdy_val = 1'b1;
    @(negedge clk);
    check("release_req_ready", 32'(req_ready_o), 32'd1);
    @(posedge clk); #1;
    rdy_val = 1'b0;
    send(2, 1'b0);
    drive(3);
    req_valid_i = 1'b1;
    restart_i = 1'b1;
    @(negedge clk);
    check("restart_req_ready", 32'(req_ready_o), 32'd0);
    sb.delete();
    exp_addr = '0;
    @(posedge clk); #1;
    restart_i = 1'b0;
    req_valid_i = 1'b0;
    @(negedge clk);
    check("restart_wr_valid", 32'(wr_valid_o), 32'd0);
    check("restart_err", 32'(err_o), 32'd0);
    check("restart_count", 32'(count_o), 32'd0);
    @(posedge clk); #1;
    rdy_val = 1'b1;
    send(4, 1'b1);
    drain();

    // Asynchronous reset in the middle of a stream.
    send(5, 1'b0);
    send(6, 1'b0);
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("async");
    sb.delete();
    exp_addr = '0;
    @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk); #1;
    send(7, 1'b1);
    drain();
    check("post_reset_count", 32'(count_o), 32'd1);

    // Address wrap with a 2-bit address.
    rv2 = 1'b1;
    acc = 0;
    for (int b = 0; b < 50 && acc < 5; b++) begin
      @(negedge clk);
      if (rr2) acc++;
      @(posedge clk); #1;
      if (acc == 5) rv2 = 1'b0;
    end
    rv2 = 1'b0;
    if (acc != 5) fail_now("wrap_accept");
    repeat (6) begin @(posedge clk); #1; end
    check("wrap_words", 32'(q2.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      logic [1:0] a;
      a = (i < q2.size()) ? q2[i] : 2'bxx;
      check($sformatf("wrap_addr%0d", i), 32'(a), 32'(i % 4));
    end
    check("wrap_count", 32'(cnt2), 32'd5);
    check("wrap_err", 32'(err2), 32'd0);
    check("wrap_data", wd2, 32'h0010_0093);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
